lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 137 +++++++++++++
 tb/tb_lsu.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Single-port load/store unit: RV32I byte/half/word accesses onto a word-wide data memory.
// Sub-word stores are done as a read-modify-write. One request is in flight at a time.
module lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_load,
    output logic        mem_store,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, DONE} state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    state_t      state;
    lsu_req_t    r;
    logic [31:0] merge;
    logic        bad;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ld_val;
    logic [31:0] merged;

    // Decode the live request so the accept edge can branch straight to DONE on error.
    always_comb begin
        bad = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7)
           || (req_we && req_funct3[2])
           || ((req_funct3[1:0] == 2'b01) && req_addr[0])
           || ((req_funct3 == 3'd2) && (req_addr[1:0] != 2'b00));
    end

    always_comb begin
        byte_v = mem_rdata[{r.addr[1:0], 3'b000} +: 8];
        half_v = mem_rdata[{r.addr[1], 4'b0000} +: 16];
        case (r.f3)
            3'd0:    ld_val = {{24{byte_v[7]}}, byte_v};
            3'd1:    ld_val = {{16{half_v[15]}}, half_v};
            3'd4:    ld_val = {24'h0, byte_v};
            3'd5:    ld_val = {16'h0, half_v};
            default: ld_val = mem_rdata;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        if (r.f3[0])
            merged[{r.addr[1], 4'b0000} +: 16] = r.wdata[15:0];
        else
            merged[{r.addr[1:0], 3'b000} +: 8] = r.wdata[7:0];
    end

    assign req_ready = (state == IDLE) && !rst;
    assign mem_addr  = (state == IDLE) ? 32'h0 : {r.addr[31:2], 2'b00};
    assign mem_wdata = mem_store ? (r.f3[1] ? r.wdata : merge) : 32'h0;

    // Strobes are registered alongside the state so they exactly track it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            r          <= '0;
            merge      <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_load   <= 1'b0;
            mem_store  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    r <= '{we: req_we, f3: req_funct3, addr: req_addr, wdata: req_wdata};
                    if (bad) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else if (!req_we) begin
                        state    <= LOAD;
                        mem_load <= 1'b1;
                    end else if (req_funct3 == 3'd2) begin
                        state     <= WRITE;
                        mem_store <= 1'b1;
                    end else begin
                        state    <= RMW_RD;
                        mem_load <= 1'b1;
                    end
                end
                LOAD: begin
                    state      <= DONE;
                    mem_load   <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_rdata <= ld_val;
                    resp_err   <= 1'b0;
                end
                RMW_RD: begin
                    state     <= WRITE;
                    mem_load  <= 1'b0;
                    mem_store <= 1'b1;
                    merge     <= merged;
                end
                WRITE: begin
                    state      <= DONE;
                    mem_store  <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                DONE: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    mem_load   <= 1'b0;
                    mem_store  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus random traffic against a byte-level memory model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_load;
    logic        mem_store;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];

    lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_load(mem_load), .mem_store(mem_store), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_load ? mem[mem_addr[11:2]] : 32'h0;
    always @(posedge clk) if (mem_store) mem[mem_addr[11:2]] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
        if (we && (f3 == 4 || f3 == 5)) return 1'b1;
        if ((f3 == 1 || f3 == 5) && (a % 2 != 0)) return 1'b1;
        if (f3 == 2 && (a % 4 != 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
        logic [7:0] b [4];
        int k;
        int v;
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        k = a % 4;
        case (f3)
            3'd0: begin v = b[k];                 if (v >= 128)   v -= 256;   end
            3'd1: begin v = b[k] + 256 * b[k+1];  if (v >= 32768) v -= 65536; end
            3'd4: v = b[k];
            3'd5: v = b[k] + 256 * b[k+1];
            default: return w;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] a,
                                                input logic [2:0] f3, input logic [31:0] d);
        logic [7:0] b [4];
        int k;
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        k = a % 4;
        if (f3 == 2) return d;
        b[k] = d[7:0];
        if (f3 == 1) b[k+1] = d[15:8];
        return {b[3], b[2], b[1], b[0]};
    endfunction

    // One full transaction: latency, strobe counts, store data, response and hold are checked.
    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int w, lat, nld, nst, elat, eld, est;
        logic [31:0] lw, erd, nw;
        logic ee;
        int idx;
        w = 0;
        while (!req_ready && w < 10) begin @(negedge clk); w++; end
        chk("ready_before_req", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; nld = 0; nst = 0; lw = 32'h0;
        do begin
            @(negedge clk);
            lat++;
            if (mem_load) nld++;
            if (mem_store) begin nst++; lw = mem_wdata; end
            chk("ld_st_exclusive", {31'h0, mem_load & mem_store}, 32'h0);
            chk("ready_busy", {31'h0, req_ready}, 32'h0);
            if (mem_load | mem_store) chk("mem_addr", mem_addr, {a[31:2], 2'b00});
            if (!mem_store) chk("wdata_idle", mem_wdata, 32'h0);
        end while (!resp_valid && lat < 8);

        idx = a[11:2];
        ee  = is_err(we, f3, a);
        erd = 32'h0;
        nw  = ref_mem[idx];
        if (ee) begin elat = 1; eld = 0; est = 0; end
        else if (!we) begin elat = 2; eld = 1; est = 0; erd = model_load(ref_mem[idx], a, f3); end
        else if (f3 == 2) begin elat = 2; eld = 0; est = 1; nw = model_store(nw, a, f3, wd); end
        else begin elat = 3; eld = 1; est = 1; nw = model_store(nw, a, f3, wd); end
        ref_mem[idx] = nw;

        chk("latency", 32'(lat), 32'(elat));
        chk("mem_load_cycles", 32'(nld), 32'(eld));
        chk("mem_store_cycles", 32'(nst), 32'(est));
        chk("resp_err", {31'h0, resp_err}, {31'h0, ee});
        chk("resp_rdata", resp_rdata, erd);
        if (we && !ee) chk("store_word", lw, nw);
        chk("mem_word", mem[idx], ref_mem[idx]);
        @(negedge clk);
        chk("resp_pulse", {31'h0, resp_valid}, 32'h0);
        chk("rdata_hold", resp_rdata, erd);
        chk("err_hold", {31'h0, resp_err}, {31'h0, ee});
        chk("addr_idle", mem_addr, 32'h0);
    endtask

    initial begin
        int acc, nst, nrv;
        logic [31:0] a;
        logic [2:0]  f3;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[32'h100 >> 2] = 32'h8899AABB; ref_mem[32'h100 >> 2] = 32'h8899AABB;
        mem[32'h200 >> 2] = 32'h11223344; ref_mem[32'h200 >> 2] = 32'h11223344;

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", {31'h0, resp_err}, 32'h0);
        chk("rst_load", {31'h0, mem_load}, 32'h0);
        chk("rst_store", {31'h0, mem_store}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        rst = 1'b0;
        #1 chk("ready_after_rst", {31'h0, req_ready}, 32'h1);

        run(1'b0, 3'd0, 32'h102, 32'h0);
        chk("lb_0x102", resp_rdata, 32'hFFFFFF99);
        run(1'b0, 3'd4, 32'h102, 32'h0);
        chk("lbu_0x102", resp_rdata, 32'h00000099);
        run(1'b1, 3'd1, 32'h202, 32'hDEADBEEF);
        chk("sh_word", mem[32'h200 >> 2], 32'hBEEF3344);
        run(1'b0, 3'd2, 32'h200, 32'h0);
        chk("lw_after_sh", resp_rdata, 32'hBEEF3344);
        run(1'b0, 3'd2, 32'h103, 32'h0);
        run(1'b1, 3'd1, 32'h201, 32'h12345678);
        run(1'b1, 3'd4, 32'h204, 32'h12345678);
        run(1'b0, 3'd3, 32'h208, 32'h0);
        run(1'b1, 3'd0, 32'h2F3, 32'hA5A5A5C3);
        run(1'b1, 3'd2, 32'h2F4, 32'hCAFEF00D);

        // Reset during the read half of an SB must abort with no write and no response.
        a = 32'h3A1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = a; req_wdata = 32'h77;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_in_rmw", {31'h0, mem_load}, 32'h1);
        rst = 1'b1;
        #1;
        chk("abort_store", {31'h0, mem_store}, 32'h0);
        chk("abort_load", {31'h0, mem_load}, 32'h0);
        chk("abort_ready", {31'h0, req_ready}, 32'h0);
        chk("abort_rdata", resp_rdata, 32'h0);
        nst = 0; nrv = 0;
        repeat (3) begin @(negedge clk); nst += mem_store; nrv += resp_valid; end
        rst = 1'b0;
        #1 chk("abort_ready_release", {31'h0, req_ready}, 32'h1);
        repeat (4) begin @(negedge clk); nst += mem_store; nrv += resp_valid; end
        chk("abort_no_store", 32'(nst), 32'h0);
        chk("abort_no_resp", 32'(nrv), 32'h0);
        chk("abort_word", mem[a[11:2]], ref_mem[a[11:2]]);

        // Held request: one accept per IDLE visit, ready low while busy.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h300;
        acc = 0;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            if (req_ready) acc++;
            if (mem_load || resp_valid) chk("held_ready_low", {31'h0, req_ready}, 32'h0);
            if (resp_valid) chk("held_rdata", resp_rdata, ref_mem[32'h300 >> 2]);
        end
        req_valid = 1'b0;
        chk("held_accepts", 32'(acc), 32'd3);
        @(negedge clk);

        for (int n = 0; n < 150; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 32'hFFF));
            if (($urandom % 4) != 0) begin
                if (f3 == 3'd1 || f3 == 3'd5) a[0] = 1'b0;
                if (f3 == 3'd2) a[1:0] = 2'b00;
            end
            run(1'($urandom), f3, a, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
